// File: rtl/linear_layer_start_fifo_ctrl.sv
// Start-token FIFO controller: SRL-style storage (shift on write, indexed read), first-word-fall-through head.
// Define START_FIFO_AFULL_EN to add the registered if_almost_full_n output.
module linear_layer_start_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
`ifdef START_FIFO_AFULL_EN
  output logic                  if_almost_full_n,
`endif
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  full_n_q, empty_n_q;
  logic                  push, pop;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read  & if_read_ce  & empty_n_q;

  // rd_addr tracks count-1, but is held across count=0 so it stays 0 there.
  always_comb begin
    count_d   = count_q;
    rd_addr_d = rd_addr_q;
    case ({push, pop})
      2'b10: begin
        count_d = count_q + CNT_ONE;
        if (count_q != '0) rd_addr_d = rd_addr_q + ADR_ONE;
      end
      2'b01: begin
        count_d = count_q - CNT_ONE;
        if (count_q != CNT_ONE) rd_addr_d = rd_addr_q - ADR_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      rd_addr_q <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      full_n_q  <= (count_d != DEPTH_C);
      empty_n_q <= (count_d != '0);
    end
  end

  // Storage is not reset; a push coinciding with reset is still dropped.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[0] <= if_din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

`ifdef START_FIFO_AFULL_EN
  // For DEPTH=1 the threshold collapses onto the full condition.
  localparam logic [ADDR_WIDTH:0] AF_THR_C = CW'((DEPTH == 1) ? 1 : DEPTH - 1);
  logic afull_n_q;

  always_ff @(posedge clk) begin
    if (reset) afull_n_q <= 1'b1;
    else       afull_n_q <= (count_d < AF_THR_C);
  end

  assign if_almost_full_n = afull_n_q;
`endif

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign if_dout    = mem_q[rd_addr_q];

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Self-checking bench for linear_layer_start_fifo_ctrl (DEPTH=2, DATA_WIDTH=8): vector table, reset sequence, random vs queue model.
module tb_linear_layer_start_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 1;
  localparam int DP = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_write_ce, if_write, if_read_ce, if_read;
  logic [DW-1:0] if_din;
  logic          if_full_n, if_empty_n;
  logic [DW-1:0] if_dout;
  logic          dut_af_n;

  int n_cmp  = 0;
  int n_fail = 0;

  linear_layer_start_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .if_write_ce     (if_write_ce),
    .if_write        (if_write),
    .if_din          (if_din),
    .if_full_n       (if_full_n),
`ifdef START_FIFO_AFULL_EN
    .if_almost_full_n(dut_af_n),
`endif
    .if_read_ce      (if_read_ce),
    .if_read         (if_read),
    .if_dout         (if_dout),
    .if_empty_n      (if_empty_n)
  );

`ifndef START_FIFO_AFULL_EN
  assign dut_af_n = 1'b1;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic          wce, wr;
    logic [DW-1:0] din;
    logic          rce, rd;
    logic          exp_full_n, exp_empty_n, exp_af_n;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wce, logic wr, logic [DW-1:0] din, logic rce, logic rd,
                              logic f, logic e, logic af, logic [DW-1:0] dout);
    vec_t v;
    v.wce = wce; v.wr = wr; v.din = din; v.rce = rce; v.rd = rd;
    v.exp_full_n = f; v.exp_empty_n = e; v.exp_af_n = af; v.exp_dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wce, input logic wr, input logic [DW-1:0] din,
                       input logic rce, input logic rd);
    if_write_ce = wce; if_write = wr; if_din = din; if_read_ce = rce; if_read = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic f, input logic e, input logic af);
    chk({tag, ".full_n"}, 32'(if_full_n), 32'(f));
    chk({tag, ".empty_n"}, 32'(if_empty_n), 32'(e));
`ifdef START_FIFO_AFULL_EN
    chk({tag, ".afull_n"}, 32'(dut_af_n), 32'(af));
`else
    if (af === 1'bx) $display("unexpected x in expectation for %s", tag);
`endif
  endtask

  logic [DW-1:0] model_q[$];

  initial begin
    // Vector table: one edge per row, expectations after that edge (count in comment).
    vecs.push_back(mk(1, 0, 8'h00, 1, 1, 1, 0, 1, 8'h00)); // c0 read while empty
    vecs.push_back(mk(1, 1, 8'hA1, 0, 0, 1, 1, 0, 8'hA1)); // c1
    vecs.push_back(mk(1, 1, 8'hB2, 0, 0, 0, 1, 0, 8'hA1)); // c2 full
    vecs.push_back(mk(1, 1, 8'hC3, 0, 0, 0, 1, 0, 8'hA1)); // write while full ignored
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 0, 8'hB2)); // c1
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 1, 8'h00)); // c0
    vecs.push_back(mk(1, 1, 8'h11, 0, 0, 1, 1, 0, 8'h11)); // c1
    vecs.push_back(mk(1, 1, 8'h22, 1, 1, 1, 1, 0, 8'h22)); // push+pop at c1
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 1, 8'h00)); // c0
    vecs.push_back(mk(1, 1, 8'h33, 0, 0, 1, 1, 0, 8'h33)); // c1
    vecs.push_back(mk(1, 1, 8'h44, 0, 0, 0, 1, 0, 8'h33)); // c2
    vecs.push_back(mk(1, 1, 8'h55, 1, 1, 1, 1, 0, 8'h44)); // full: pop only
    vecs.push_back(mk(0, 1, 8'h66, 0, 0, 1, 1, 0, 8'h44)); // ce gated
    vecs.push_back(mk(0, 0, 8'h66, 0, 1, 1, 1, 0, 8'h44));
    vecs.push_back(mk(0, 1, 8'h66, 0, 1, 1, 1, 0, 8'h44));
    vecs.push_back(mk(0, 1, 8'h67, 0, 1, 1, 1, 0, 8'h44));
    vecs.push_back(mk(0, 1, 8'h68, 0, 1, 1, 1, 0, 8'h44));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 1, 8'h00)); // c0, 0x55 never seen
    vecs.push_back(mk(1, 1, 8'h77, 1, 1, 1, 1, 0, 8'h77)); // empty: push only
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 1, 8'h00)); // c0

    drive(0, 0, '0, 0, 0);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_flags("reset", 1, 0, 1);

    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'hFF, 1, 1);
      tick();
      chk_flags($sformatf("idle%0d", i), 1, 0, 1);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].wce, vecs[i].wr, vecs[i].din, vecs[i].rce, vecs[i].rd);
      tick();
      chk_flags($sformatf("vec%0d", i), vecs[i].exp_full_n, vecs[i].exp_empty_n, vecs[i].exp_af_n);
      if (vecs[i].exp_empty_n)
        chk($sformatf("vec%0d.dout", i), 32'(if_dout), 32'(vecs[i].exp_dout));
    end

    // Reset at count=2 with a concurrent push.
    drive(1, 1, 8'h88, 0, 0); tick();
    chk_flags("rst_seq.p1", 1, 1, 0);
    drive(1, 1, 8'h99, 0, 0); tick();
    chk_flags("rst_seq.p2", 0, 1, 0);
    chk("rst_seq.dout", 32'(if_dout), 32'h88);
    drive(1, 1, 8'hAA, 1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_flags("rst_seq.rst", 1, 0, 1);
    drive(0, 0, '0, 0, 0); tick();
    chk_flags("rst_seq.after", 1, 0, 1);
    drive(1, 1, 8'hBB, 0, 0); tick();
    chk_flags("rst_seq.push", 1, 1, 0);
    chk("rst_seq.dout2", 32'(if_dout), 32'hBB);
    drive(0, 0, '0, 1, 1); tick();
    chk_flags("rst_seq.pop", 1, 0, 1);

    // Randomized traffic against a queue model.
    model_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic wce, wr, rce, rd, rst, do_push, do_pop;
      logic [DW-1:0] din;
      wce = ($urandom_range(0, 3) != 0);
      wr  = $urandom_range(0, 1) == 1;
      rce = ($urandom_range(0, 3) != 0);
      rd  = $urandom_range(0, 1) == 1;
      din = DW'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      drive(wce, wr, din, rce, rd);
      reset = rst;
      do_push = wce && wr && (model_q.size() < DP);
      do_pop  = rce && rd && (model_q.size() > 0);
      tick();
      reset = 1'b0;
      if (rst) begin
        model_q.delete();
      end else begin
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(din);
      end
      chk_flags($sformatf("rnd%0d", cyc), model_q.size() != DP, model_q.size() != 0,
                model_q.size() < DP - 1);
      if (model_q.size() > 0)
        chk($sformatf("rnd%0d.dout", cyc), 32'(if_dout), 32'(model_q[0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
